// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writable CPU program memory, filled by a host over a checksummed valid/ready stream.
module prog_mem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adrs,
    output logic [DATA_W-1:0] dat_out,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic              ld_err
);
    typedef enum logic [2:0] {EMPTY, LOAD, CHECK, RUN, ERROR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] total;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;

    // ld_start outranks any word offered in the same cycle
    assign accept   = ld_valid & ld_ready & ~ld_start;
    assign total    = sum + ld_data;
    assign ld_ready = (state == LOAD) || (state == CHECK);
    assign cpu_hold = state != RUN;
    assign ld_done  = state == RUN;
    assign ld_err   = state == ERROR;

    if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        assign in_range = 32'(adrs) < DEPTH;
    end

    assign dat_out = (cpu_hold || !in_range) ? '0 : mem[adrs];

    always_comb begin
        state_nxt = state;
        if (ld_start)
            state_nxt = LOAD;
        else if (accept && state == LOAD && ptr == ADDR_W'(DEPTH - 1))
            state_nxt = CHECK;
        else if (accept && state == CHECK)
            state_nxt = (total == '0) ? RUN : ERROR;
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state <= EMPTY;
            ptr   <= '0;
            sum   <= '0;
        end else begin
            state <= state_nxt;
            if (ld_start) begin
                ptr <= '0;
                sum <= '0;
            end else if (accept && state == LOAD) begin
                ptr <= ptr + ADDR_W'(1);
                sum <= total;
            end
        end
    end

    // Array is deliberately not reset; contents are untrusted until a verified load
    always_ff @(posedge clk_cpu) begin
        if (accept && state == LOAD)
            mem[ptr] <= ld_data;
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed checks of load, checksum, restart, reset and fetch behaviour.
module tb_prog_mem_loader;
    logic       clk_cpu = 0;
    logic       reset = 1;
    logic [3:0] adrs = 0;
    logic [7:0] dat_out;
    logic       ld_start = 0;
    logic       ld_valid = 0;
    logic [7:0] ld_data = 0;
    logic       ld_ready, cpu_hold, ld_done, ld_err;
    int         checks = 0;
    int         errors = 0;

    prog_mem_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .adrs(adrs), .dat_out(dat_out),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_done(ld_done), .ld_err(ld_err)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic pulse_start();
        ld_start = 1;
        @(posedge clk_cpu); #1;
        ld_start = 0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit gaps);
        int n = 0;
        if (gaps && $urandom_range(1) == 1) begin
            @(posedge clk_cpu); #1;
        end
        ld_valid = 1;
        ld_data  = d;
        @(negedge clk_cpu);
        while (!ld_ready && n < 50) begin
            @(negedge clk_cpu);
            n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL send_word timeout: ld_ready=%b required 1", ld_ready);
        end
        @(posedge clk_cpu); #1;
        ld_valid = 0;
    endtask

    task automatic load_image(input logic [7:0] base, input logic [7:0] csum, input bit gaps);
        for (int i = 0; i < 16; i++) send_word(base + 8'(i), gaps);
        send_word(csum, gaps);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk_cpu);
        #1 reset = 0;
        @(posedge clk_cpu); #1;
        checks += 5;
        if (ld_ready !== 0) begin errors++; $display("FAIL reset ld_ready: got %b required 0", ld_ready); end
        if (cpu_hold !== 1) begin errors++; $display("FAIL reset cpu_hold: got %b required 1", cpu_hold); end
        if (ld_done !== 0) begin errors++; $display("FAIL reset ld_done: got %b required 0", ld_done); end
        if (ld_err !== 0) begin errors++; $display("FAIL reset ld_err: got %b required 0", ld_err); end
        if (dat_out !== 8'h00) begin errors++; $display("FAIL reset dat_out: got %h required 00", dat_out); end
    endtask

    task automatic test_good_load();
        pulse_start();
        checks++;
        if (ld_ready !== 1) begin errors++; $display("FAIL good ld_ready in LOAD: got %b required 1", ld_ready); end
        load_image(8'h01, 8'h78, 0);
        adrs = 5; #1;
        checks += 5;
        if (ld_done !== 1) begin errors++; $display("FAIL good ld_done: got %b required 1", ld_done); end
        if (cpu_hold !== 0) begin errors++; $display("FAIL good cpu_hold: got %b required 0", cpu_hold); end
        if (ld_ready !== 0) begin errors++; $display("FAIL good ld_ready: got %b required 0", ld_ready); end
        if (ld_err !== 0) begin errors++; $display("FAIL good ld_err: got %b required 0", ld_err); end
        if (dat_out !== 8'h06) begin errors++; $display("FAIL good fetch[5]: got %h required 06", dat_out); end
        adrs = 15; #1;
        checks++;
        if (dat_out !== 8'h10) begin errors++; $display("FAIL good fetch[15]: got %h required 10", dat_out); end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        load_image(8'h01, 8'h77, 0);
        adrs = 5; #1;
        checks += 4;
        if (ld_err !== 1) begin errors++; $display("FAIL bad ld_err: got %b required 1", ld_err); end
        if (cpu_hold !== 1) begin errors++; $display("FAIL bad cpu_hold: got %b required 1", cpu_hold); end
        if (ld_done !== 0) begin errors++; $display("FAIL bad ld_done: got %b required 0", ld_done); end
        if (dat_out !== 8'h00) begin errors++; $display("FAIL bad dat_out: got %h required 00", dat_out); end
        ld_valid = 1; ld_data = 8'h5A;
        repeat (3) @(posedge clk_cpu);
        #1 ld_valid = 0;
        checks += 2;
        if (ld_err !== 1) begin errors++; $display("FAIL bad stays ERROR: got %b required 1", ld_err); end
        if (ld_ready !== 0) begin errors++; $display("FAIL bad ld_ready: got %b required 0", ld_ready); end
        pulse_start();
        load_image(8'h01, 8'h78, 0);
        checks += 2;
        if (ld_done !== 1) begin errors++; $display("FAIL bad reload ld_done: got %b required 1", ld_done); end
        if (ld_err !== 0) begin errors++; $display("FAIL bad reload ld_err: got %b required 0", ld_err); end
    endtask

    task automatic test_gaps();
        pulse_start();
        load_image(8'h00, 8'h88, 1);
        checks++;
        if (ld_done !== 1) begin errors++; $display("FAIL gaps ld_done: got %b required 1", ld_done); end
        for (int i = 0; i < 16; i++) begin
            adrs = 4'(i); #1;
            checks++;
            if (dat_out !== 8'(i)) begin errors++; $display("FAIL gaps fetch[%0d]: got %h required %h", i, dat_out, 8'(i)); end
        end
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 7; i++) send_word(8'hFF, 0);
        ld_valid = 1; ld_data = 8'hAA; ld_start = 1;
        @(posedge clk_cpu); #1;
        ld_start = 0; ld_valid = 0;
        load_image(8'h01, 8'h78, 0);
        adrs = 0; #1;
        checks += 3;
        if (ld_done !== 1) begin errors++; $display("FAIL restart ld_done: got %b required 1", ld_done); end
        if (ld_err !== 0) begin errors++; $display("FAIL restart ld_err: got %b required 0", ld_err); end
        if (dat_out !== 8'h01) begin errors++; $display("FAIL restart fetch[0]: got %h required 01", dat_out); end
        adrs = 6; #1;
        checks++;
        if (dat_out !== 8'h07) begin errors++; $display("FAIL restart fetch[6]: got %h required 07", dat_out); end
    endtask

    task automatic test_reset_midload();
        pulse_start();
        for (int i = 0; i < 9; i++) send_word(8'h55, 0);
        reset = 1;
        @(posedge clk_cpu); #1;
        reset = 0;
        adrs = 3; #1;
        checks += 5;
        if (ld_ready !== 0) begin errors++; $display("FAIL midreset ld_ready: got %b required 0", ld_ready); end
        if (cpu_hold !== 1) begin errors++; $display("FAIL midreset cpu_hold: got %b required 1", cpu_hold); end
        if (ld_done !== 0) begin errors++; $display("FAIL midreset ld_done: got %b required 0", ld_done); end
        if (ld_err !== 0) begin errors++; $display("FAIL midreset ld_err: got %b required 0", ld_err); end
        if (dat_out !== 8'h00) begin errors++; $display("FAIL midreset dat_out: got %h required 00", dat_out); end
        ld_valid = 1; ld_data = 8'h11;
        repeat (3) @(posedge clk_cpu);
        #1 ld_valid = 0;
        checks++;
        if (ld_ready !== 0) begin errors++; $display("FAIL midreset idle ld_ready: got %b required 0", ld_ready); end
        pulse_start();
        checks++;
        if (ld_ready !== 1) begin errors++; $display("FAIL midreset restart ld_ready: got %b required 1", ld_ready); end
        load_image(8'h01, 8'h78, 0);
        checks++;
        if (ld_done !== 1) begin errors++; $display("FAIL midreset reload ld_done: got %b required 1", ld_done); end
    endtask

    task automatic test_start_in_run();
        adrs = 0; #1;
        checks++;
        if (dat_out !== 8'h01) begin errors++; $display("FAIL run fetch before restart: got %h required 01", dat_out); end
        pulse_start();
        checks += 3;
        if (cpu_hold !== 1) begin errors++; $display("FAIL run restart cpu_hold: got %b required 1", cpu_hold); end
        if (dat_out !== 8'h00) begin errors++; $display("FAIL run restart dat_out: got %h required 00", dat_out); end
        if (ld_done !== 0) begin errors++; $display("FAIL run restart ld_done: got %b required 0", ld_done); end
        load_image(8'h21, 8'h78, 0);
        #1;
        checks += 2;
        if (ld_done !== 1) begin errors++; $display("FAIL run new ld_done: got %b required 1", ld_done); end
        if (dat_out !== 8'h21) begin errors++; $display("FAIL run new fetch[0]: got %h required 21", dat_out); end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_gaps();
        test_restart();
        test_reset_midload();
        test_start_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
